rf_wr_arbiter: RTL and testbench

Arbitrates the single write port of the CPU's 32-entry register file among several writeback requesters (pipeline writeback, load unit, multi-cycle mul/div). Uses a valid/ready handshake per requester and a registered output stage that drives the register file's write port directly. Exports a one-hot mask of the register about to be written, so hazard logic can stall readers until the write lands.

---
 rtl/rf_wr_arbiter.sv | 131 +++++++++++++
 tb/tb_rf_wr_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wr_arbiter.sv
// rtl/rf_wr_arbiter.sv - register file write-port arbiter with registered output stage
//
// Picks one writeback requester per cycle and registers its address and data
// onto the register file write port. The output stage drains every cycle, so
// it never back-pressures.
//
// Optional feature: define RF_WR_ARB_RR_EN for round-robin arbitration.
// Without it, priority is fixed and requester 0 is highest.
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   req_valid      per-requester write request
//   req_addr       5-bit destination per requester; requester i is [5i+4:5i]
//   req_data       DATA_WIDTH write data per requester; requester i is slice i
//   req_ready      one-hot grant, combinational; forced low while in reset
//   rf_wr_en       register file write enable; low for writes to x0
//   rf_addr_wr     register file write address; holds when idle
//   rf_data_wr     register file write data; holds when idle
//   pend_mask      one-hot mask of the register in the output stage
//   wr_count       saturating count of accepted non-x0 writes
module rf_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*5-1:0]          req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rf_wr_en,
    output logic [4:0]                    rf_addr_wr,
    output logic [DATA_WIDTH-1:0]         rf_data_wr,
    output logic [31:0]                   pend_mask,
    output logic [15:0]                   wr_count
);

    // Index of the winning requester this cycle, -1 when nobody is requesting.
    int win;

`ifdef RF_WR_ARB_RR_EN
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Pointer names the requester with highest priority this cycle.
    logic [PTR_W-1:0] rr_ptr;

    function automatic int rr_index(input int base, input int offset);
        int s;
        s = base + offset;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return s;
    endfunction

    always_comb begin
        win = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win < 0 && req_valid[rr_index(int'(rr_ptr), k)]) begin
                win = rr_index(int'(rr_ptr), k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (win >= 0) begin
            rr_ptr <= PTR_W'(rr_index(win, 1));
        end
    end
`else
    always_comb begin
        win = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win < 0 && req_valid[k]) begin
                win = k;
            end
        end
    end
`endif

    logic                  xfer;
    logic [4:0]            sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    // Grant and selected payload. Readiness is gated by rst_n so nothing
    // appears accepted while reset is held.
    always_comb begin
        req_ready = '0;
        sel_addr  = '0;
        sel_data  = '0;
        xfer      = rst_n && (win >= 0);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i == win) begin
                req_ready[i] = rst_n;
                sel_addr     = req_addr[5*i +: 5];
                sel_data     = req_data[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    // Output stage. A write to x0 completes the handshake but never reaches
    // the register file and is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wr_en   <= 1'b0;
            rf_addr_wr <= '0;
            rf_data_wr <= '0;
            wr_count   <= '0;
        end else begin
            rf_wr_en <= xfer && (sel_addr != 5'd0);
            if (xfer) begin
                rf_addr_wr <= sel_addr;
                rf_data_wr <= sel_data;
                if (sel_addr != 5'd0 && wr_count != 16'hFFFF) begin
                    wr_count <= wr_count + 16'd1;
                end
            end
        end
    end

    // Bit 0 can never be set: rf_wr_en is only high for non-zero addresses.
    always_comb begin
        pend_mask = '0;
        if (rf_wr_en) begin
            pend_mask[rf_addr_wr] = 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb/tb_rf_wr_arbiter.sv - scoreboard bench for rf_wr_arbiter
module tb_rf_wr_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid;
    logic [N*5-1:0]   req_addr;
    logic [N*DW-1:0]  req_data;
    logic [N-1:0]     req_ready;
    logic             rf_wr_en;
    logic [4:0]       rf_addr_wr;
    logic [DW-1:0]    rf_data_wr;
    logic [31:0]      pend_mask;
    logic [15:0]      wr_count;

    rf_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rf_wr_en   (rf_wr_en),
        .rf_addr_wr (rf_addr_wr),
        .rf_data_wr (rf_data_wr),
        .pend_mask  (pend_mask),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          en;
        logic [4:0]  addr;
        logic [31:0] data;
        int          count;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    // Reference model state: outstanding requests, priority pointer, count.
    bit          pend[N];
    logic [4:0]  p_addr[N];
    logic [31:0] p_data[N];
    int          m_ptr;
    int          m_count;
    int          last_win;
    int          wins[6];
    logic [31:0] tb_rf[32];

    always @(posedge clk) cyc <= cyc + 1;

    // Register file fed by the DUT write port, used for read-after-write checks.
    always @(posedge clk) begin
        if (rst_n && rf_wr_en) tb_rf[rf_addr_wr] <= rf_data_wr;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares the output stage against the expected record due this cycle.
    exp_t m_e;
    always @(negedge clk) begin
        if (rst_n && sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            m_e = sb_q.pop_front();
            check("sb_due", cyc, m_e.due);
            check("rf_wr_en", rf_wr_en, m_e.en);
            check("pend_mask", pend_mask, m_e.en ? (32'h1 << m_e.addr) : 32'h0);
            check("wr_count", wr_count, m_e.count);
            if (m_e.en) begin
                check("rf_addr_wr", rf_addr_wr, m_e.addr);
                check("rf_data_wr", rf_data_wr, m_e.data);
            end
        end
    end

    // One clock of stimulus: present outstanding requests, check the grant
    // against the priority rule, and queue the expected output for next cycle.
    task automatic step();
        int         win;
        int         j;
        logic [N-1:0] exp_ready;
        exp_t       e;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = pend[i];
            req_addr[5*i +: 5]    = p_addr[i];
            req_data[DW*i +: DW]  = p_data[i];
        end
        #1;
        win = -1;
        for (int k = 0; k < N; k++) begin
`ifdef RF_WR_ARB_RR_EN
            j = (m_ptr + k) % N;
`else
            j = k;
`endif
            if (win < 0 && pend[j]) win = j;
        end
        exp_ready = '0;
        e.due   = cyc + 1;
        e.en    = 1'b0;
        e.addr  = '0;
        e.data  = '0;
        if (win >= 0) begin
            exp_ready[win] = 1'b1;
            e.addr = p_addr[win];
            e.data = p_data[win];
            e.en   = (p_addr[win] != 5'd0);
            if (e.en && m_count < 65535) m_count++;
            m_ptr = (win + 1) % N;
            pend[win] = 1'b0;
        end
        e.count = m_count;
        check("req_ready", req_ready, exp_ready);
        last_win = win;
        sb_q.push_back(e);
    endtask

    task automatic new_requests(input int pct);
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 99) < pct) begin
                pend[i]   = 1'b1;
                p_addr[i] = 5'($urandom_range(0, 31));
                p_data[i] = $urandom;
            end
        end
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("rst_rf_wr_en", rf_wr_en, 1'b0);
        check("rst_wr_count", wr_count, 16'h0);
        check("rst_pend_mask", pend_mask, 32'h0);
        check("rst_req_ready", req_ready, '0);
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        req_valid = '0;
        m_ptr     = 0;
        m_count   = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        m_ptr     = 0;
        m_count   = 0;
        last_win  = -1;
        for (int i = 0; i < N; i++) begin
            pend[i]   = 1'b0;
            p_addr[i] = '0;
            p_data[i] = '0;
        end

        // Reset state, with all requests asserted to see readiness held low.
        repeat (2) @(posedge clk);
        #1;
        req_valid = '1;
        #1;
        check("reset_req_ready", req_ready, '0);
        check("reset_rf_wr_en", rf_wr_en, 1'b0);
        check("reset_rf_addr_wr", rf_addr_wr, 5'd0);
        check("reset_rf_data_wr", rf_data_wr, 32'd0);
        check("reset_pend_mask", pend_mask, 32'd0);
        check("reset_wr_count", wr_count, 16'd0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single write to r5.
        pend[0] = 1'b1; p_addr[0] = 5'd5; p_data[0] = 32'hDEADBEEF;
        step();
        check("single_grant", last_win, 0);
        step();
        check("single_pend_mask", pend_mask, 32'h20);
        check("single_wr_count", wr_count, 16'd1);

        // Write to x0 is accepted but discarded.
        pend[1] = 1'b1; p_addr[1] = 5'd0; p_data[1] = 32'h12345678;
        step();
        check("x0_grant", last_win, 1);
        step();
        check("x0_wr_en", rf_wr_en, 1'b0);
        check("x0_wr_count", wr_count, 16'd1);

        // Back-to-back writes to r7; the later one must win in the register file.
        pend[0] = 1'b1; p_addr[0] = 5'd7; p_data[0] = 32'd1;
        step();
        pend[2] = 1'b1; p_addr[2] = 5'd7; p_data[2] = 32'd2;
        step();
        step();
        step();
        check("raw_r7", tb_rf[7], 32'd2);

        // Reset in the cycle after an accept.
        pend[0] = 1'b1; p_addr[0] = 5'd9; p_data[0] = $urandom;
        step();
        @(posedge clk);
        #2;
        check("midop_wr_en_before", rf_wr_en, 1'b1);
        do_reset();

        // Full contention for six cycles, starting from the reset pointer.
        for (int c = 0; c < 6; c++) begin
            new_requests(100);
            step();
            wins[c] = last_win;
        end
        for (int c = 0; c < 6; c++) begin
`ifdef RF_WR_ARB_RR_EN
            check("contention_grant", wins[c], c % 3);
`else
            check("contention_grant", wins[c], 0);
`endif
        end

        // Randomised traffic.
        repeat (400) begin
            new_requests($urandom_range(10, 90));
            step();
        end

        // Saturation: one lone requester granted every cycle past 16'hFFFF.
        do_reset();
        for (int c = 0; c < 65538; c++) begin
            pend[0]   = 1'b1;
            p_addr[0] = 5'($urandom_range(1, 31));
            p_data[0] = $urandom;
            step();
        end
        step();
        step();
        check("sat_wr_count", wr_count, 16'hFFFF);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
